// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S datapath: instruction decode, opcode table, ALU operation encoding.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    AluAdd = 2'b00,
    AluSub = 2'b01,
    AluAnd = 2'b10,
    AluOr  = 2'b11
  } alu_op_e;

  localparam logic [7:0] OpNop    = 8'h00;
  localparam logic [7:0] OpLoad   = 8'h81;
  localparam logic [7:0] OpStore  = 8'h82;
  localparam logic [7:0] OpMove   = 8'h91;
  localparam logic [7:0] OpAdd    = 8'hA1;
  localparam logic [7:0] OpSub    = 8'hA2;
  localparam logic [7:0] OpAnd    = 8'hA3;
  localparam logic [7:0] OpOr     = 8'hA4;
  localparam logic [7:0] OpBranch = 8'h01;
  localparam logic [7:0] OpBzero  = 8'h02;
  localparam logic [7:0] OpBneg   = 8'h03;
  localparam logic [7:0] OpBov    = 8'h05;
  localparam logic [7:0] OpBnov   = 8'h06;
  localparam logic [7:0] OpBnneg  = 8'h0A;
  localparam logic [7:0] OpBnzero = 8'h0B;
  localparam logic [7:0] OpHalt   = 8'hFF;

  function automatic decoded_instruction_type decode_opcode(input logic [7:0] opcode);
    decoded_instruction_type dec;
    case (opcode)
      OpLoad:   dec = I_LOAD;
      OpStore:  dec = I_STORE;
      OpMove:   dec = I_MOVE;
      OpAdd:    dec = I_ADD;
      OpSub:    dec = I_SUB;
      OpAnd:    dec = I_AND;
      OpOr:     dec = I_OR;
      OpBranch: dec = I_BRANCH;
      OpBzero:  dec = I_BZERO;
      OpBneg:   dec = I_BNEG;
      OpBov:    dec = I_BOV;
      OpBnov:   dec = I_BNOV;
      OpBnneg:  dec = I_BNNEG;
      OpBnzero: dec = I_BNZERO;
      OpHalt:   dec = I_HALT;
      default:  dec = I_NOP;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/ks_alu.sv
// Combinational ALU: add/sub/and/or with zero, negative and both overflow flags.
module ks_alu
  import k_and_s_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              neg_o,
  output logic              uov_o,
  output logic              sov_o
);
  localparam int unsigned Msb = DATA_W - 1;

  logic [DATA_W:0] wide;

  always_comb begin
    wide     = '0;
    result_o = '0;
    uov_o    = 1'b0;
    sov_o    = 1'b0;
    unique case (op_i)
      AluAdd: begin
        wide     = {1'b0, a_i} + {1'b0, b_i};
        result_o = wide[DATA_W-1:0];
        uov_o    = wide[DATA_W];
        sov_o    = (a_i[Msb] == b_i[Msb]) && (result_o[Msb] != a_i[Msb]);
      end
      AluSub: begin
        // Top bit of the widened difference is the borrow, i.e. a < b unsigned.
        wide     = {1'b0, a_i} - {1'b0, b_i};
        result_o = wide[DATA_W-1:0];
        uov_o    = wide[DATA_W];
        sov_o    = (a_i[Msb] != b_i[Msb]) && (result_o[Msb] != a_i[Msb]);
      end
      AluAnd: result_o = a_i & b_i;
      AluOr:  result_o = a_i | b_i;
    endcase
  end

  assign zero_o = (result_o == '0);
  assign neg_o  = result_o[Msb];

endmodule

// File: rtl/ks_data_path_param.sv
// K&S processor datapath: PC, IR, register file, ALU and flag register, steered by control strobes.
module ks_data_path_param
  import k_and_s_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic [DATA_W-1:0]       data_in,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out
);
  localparam int unsigned RW = $clog2(NUM_REGS);

  if ((8 + 3 * RW > DATA_W) || (8 + ADDR_W > DATA_W) || (NUM_REGS < 2) ||
      ((1 << RW) != NUM_REGS)) begin : gen_param_check
    $error("ks_data_path_param: IR fields do not fit DATA_W or NUM_REGS not a power of 2");
  end

  logic [ADDR_W-1:0]                pc_q;
  logic [DATA_W-1:0]                ir_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;

  logic [7:0]        opcode;
  logic [RW-1:0]     dst, src_a, src_b;
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W-1:0] bus_a, bus_b, bus_c, alu_result;
  logic              alu_zero, alu_neg, alu_uov, alu_sov;

  assign opcode  = ir_q[DATA_W-1 -: 8];
  assign dst     = ir_q[3*RW-1 -: RW];
  assign src_b   = ir_q[2*RW-1 -: RW];
  assign src_a   = ir_q[RW-1:0];
  assign ir_addr = ir_q[ADDR_W-1:0];

  // Padding bits between the opcode and the operand fields carry no meaning.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q;

  assign bus_a = regs_q[src_a];
  assign bus_b = regs_q[src_b];
  assign bus_c = c_sel ? data_in : alu_result;

  ks_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a_i      (bus_a),
    .b_i      (bus_b),
    .op_i     (alu_op_e'(operation)),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .neg_o    (alu_neg),
    .uov_o    (alu_uov),
    .sov_o    (alu_sov)
  );

  // All next-state terms read pre-edge values, so a same-cycle IR load cannot
  // disturb a branch target and a register write is invisible until next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q              <= '0;
      ir_q              <= '0;
      regs_q            <= '0;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else begin
      if (pc_enable) pc_q <= branch ? ir_addr : pc_q + ADDR_W'(1);
      if (ir_enable) ir_q <= data_in;
      if (write_reg_enable) regs_q[dst] <= bus_c;
      if (flags_reg_enable) begin
        zero_op           <= alu_zero;
        neg_op            <= alu_neg;
        unsigned_overflow <= alu_uov;
        signed_overflow   <= alu_sov;
      end
    end
  end

  assign decoded_instruction = decode_opcode(opcode);
  assign ram_addr            = addr_sel ? pc_q : ir_addr;
  assign data_out            = bus_a;

endmodule

// File: tb/tb_ks_data_path_param.sv
// Scoreboard bench for ks_data_path_param: default 16/4/5 build plus a 32/8/8 parameter sweep.
module tb_ks_data_path_param;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration DUT
  logic rst_n, branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable;
  logic [1:0] operation;
  logic [15:0] data_in, data_out;
  logic [4:0] ram_addr;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  decoded_instruction_type decoded_instruction;

  ks_data_path_param dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .data_in(data_in), .decoded_instruction(decoded_instruction), .zero_op(zero_op),
    .neg_op(neg_op), .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .ram_addr(ram_addr), .data_out(data_out)
  );

  // Sweep configuration DUT
  logic b_rst_n, b_branch, b_pe, b_ie, b_as, b_cs, b_we, b_fe;
  logic [1:0] b_op;
  logic [31:0] b_din, b_dout;
  logic [7:0] b_ra;
  logic b_z, b_n, b_u, b_s;
  decoded_instruction_type b_dec;

  ks_data_path_param #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(8)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .branch(b_branch), .pc_enable(b_pe), .ir_enable(b_ie),
    .addr_sel(b_as), .c_sel(b_cs), .operation(b_op), .write_reg_enable(b_we),
    .flags_reg_enable(b_fe), .data_in(b_din), .decoded_instruction(b_dec), .zero_op(b_z),
    .neg_op(b_n), .unsigned_overflow(b_u), .signed_overflow(b_s), .ram_addr(b_ra),
    .data_out(b_dout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference decode table, independent of the RTL package function
  int opc_tab [16] = '{'h00, 'h81, 'h82, 'h91, 'hA1, 'hA2, 'hA3, 'hA4,
                       'h01, 'h02, 'h0B, 'h03, 'h0A, 'h05, 'h06, 'hFF};
  decoded_instruction_type dec_tab [16] = '{I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB,
                       I_AND, I_OR, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV,
                       I_BNOV, I_HALT};
  decoded_instruction_type ref_dec [int];

  function automatic decoded_instruction_type ref_decode(input int opc);
    if (ref_dec.exists(opc)) return ref_dec[opc];
    return I_NOP;
  endfunction

  // Arithmetic reference using plain integers and signed ranges
  function automatic void ref_alu(input int op, input int a, input int b, output int r,
                                  output bit z, output bit n, output bit u, output bit s);
    int sa, sb, full;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    u = 0;
    s = 0;
    case (op)
      0: begin
        full = a + b;
        r = full % 65536;
        u = (full > 65535);
        s = (sa + sb > 32767) || (sa + sb < -32768);
      end
      1: begin
        r = (a - b + 65536) % 65536;
        u = (a < b);
        s = (sa - sb > 32767) || (sa - sb < -32768);
      end
      2: r = a & b;
      default: r = a | b;
    endcase
    z = (r == 0);
    n = (r >= 32768);
  endfunction

  typedef struct {
    string tag;
    logic [15:0] dout;
    logic [4:0] ra;
    decoded_instruction_type dec;
    logic [3:0] flags;
    bit k_on;
    logic [15:0] k_d;
    logic [3:0] k_f;
    bit kra_on;
    logic [4:0] k_ra;
  } exp_t;

  exp_t qa[$];
  exp_t mon_e;

  int m_pc, m_ir;
  int m_r [4];
  bit m_z, m_n, m_u, m_s;
  bit m_valid = 0;
  string cur_tag = "init";
  bit k_on = 0, kra_on = 0;
  logic [15:0] k_d;
  logic [3:0] k_f;
  logic [4:0] k_ra;

  task automatic expect_k(input logic [15:0] d, input logic [3:0] f);
    k_on = 1; k_d = d; k_f = f;
  endtask

  task automatic expect_ra(input logic [4:0] ra);
    kra_on = 1; k_ra = ra;
  endtask

  // Drive one cycle, enqueue what the outputs must show this cycle, advance the model.
  task automatic step(input logic rn, input logic br, input logic pe, input logic ie,
                      input logic as, input logic cs, input logic [1:0] op, input logic we,
                      input logic fe, input logic [15:0] din);
    exp_t e;
    int sa, sb, ds, ad, res;
    bit z, n, u, s;
    rst_n = rn; branch = br; pc_enable = pe; ir_enable = ie; addr_sel = as; c_sel = cs;
    operation = op; write_reg_enable = we; flags_reg_enable = fe; data_in = din;
    sa = m_ir & 3;
    sb = (m_ir >> 2) & 3;
    ds = (m_ir >> 4) & 3;
    ad = m_ir & 31;
    if (m_valid) begin
      e.tag = cur_tag;
      e.dout = 16'(m_r[sa]);
      e.ra = 5'(as ? m_pc : ad);
      e.dec = ref_decode(m_ir >> 8);
      e.flags = {m_z, m_n, m_u, m_s};
      e.k_on = k_on; e.k_d = k_d; e.k_f = k_f;
      e.kra_on = kra_on; e.k_ra = k_ra;
      qa.push_back(e);
    end
    k_on = 0;
    kra_on = 0;
    if (!rn) begin
      m_pc = 0; m_ir = 0; m_r = '{0, 0, 0, 0};
      {m_z, m_n, m_u, m_s} = 4'b0;
      m_valid = 1;
    end else begin
      ref_alu(int'(op), m_r[sa], m_r[sb], res, z, n, u, s);
      if (pe) m_pc = br ? ad : (m_pc + 1) % 32;
      if (ie) m_ir = int'(din);
      if (we) m_r[ds] = cs ? int'(din) : res;
      if (fe) {m_z, m_n, m_u, m_s} = {z, n, u, s};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ld_ir(input logic [15:0] w);
    step(1, 0, 0, 1, 1, 0, 2'd0, 0, 0, w);
  endtask
  task automatic wr(input logic [15:0] v);
    step(1, 0, 0, 0, 1, 1, 2'd0, 1, 0, v);
  endtask
  task automatic idle(input logic as);
    step(1, 0, 0, 0, as, 0, 2'd0, 0, 0, 16'h0);
  endtask
  task automatic alu(input logic [1:0] op, input logic we, input logic fe);
    step(1, 0, 0, 0, 1, 0, op, we, fe, 16'h0);
  endtask
  task automatic setreg(input int r, input logic [15:0] v);
    ld_ir(16'(r << 4));
    wr(v);
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      mon_e = qa.pop_front();
      chk({mon_e.tag, "/data_out"}, 64'(data_out), 64'(mon_e.dout));
      chk({mon_e.tag, "/ram_addr"}, 64'(ram_addr), 64'(mon_e.ra));
      chk({mon_e.tag, "/decoded"}, 64'(decoded_instruction), 64'(mon_e.dec));
      chk({mon_e.tag, "/flags"},
          64'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 64'(mon_e.flags));
      if (mon_e.k_on) begin
        chk({mon_e.tag, "/k_data_out"}, 64'(data_out), 64'(mon_e.k_d));
        chk({mon_e.tag, "/k_flags"},
            64'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 64'(mon_e.k_f));
      end
      if (mon_e.kra_on) chk({mon_e.tag, "/k_ram_addr"}, 64'(ram_addr), 64'(mon_e.k_ra));
    end
  end

  // Sweep scoreboard: hand-derived constants for the 32/8/8 build
  typedef struct {
    string tag;
    logic [31:0] dout;
    logic [7:0] ra;
  } bexp_t;
  bexp_t qb[$];
  bexp_t mon_b;

  always @(negedge clk) begin
    if (qb.size() > 0) begin
      mon_b = qb.pop_front();
      chk({mon_b.tag, "/data_out"}, 64'(b_dout), 64'(mon_b.dout));
      chk({mon_b.tag, "/ram_addr"}, 64'(b_ra), 64'(mon_b.ra));
    end
  end

  task automatic bstep(input string tag, input logic pe, input logic br, input logic ie,
                       input logic as, input logic we, input logic cs, input logic [31:0] din,
                       input logic [31:0] edout, input logic [7:0] era);
    bexp_t e;
    b_rst_n = 1; b_pe = pe; b_branch = br; b_ie = ie; b_as = as; b_we = we; b_cs = cs;
    b_op = 2'd0; b_fe = 0; b_din = din;
    e.tag = tag; e.dout = edout; e.ra = era;
    qb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] din;
    for (int i = 0; i < 16; i++) ref_dec[opc_tab[i]] = dec_tab[i];
    {b_rst_n, b_branch, b_pe, b_ie, b_as, b_cs, b_we, b_fe} = '0;
    b_op = 2'd0;
    b_din = '0;
    @(posedge clk);
    #1;
    step(0, 1, 1, 1, 1, 1, 2'd3, 1, 1, 16'hFFFF);

    cur_tag = "add_ovf";
    setreg(1, 16'h7FFF);
    setreg(2, 16'h0001);
    ld_ir(16'hA109);
    alu(2'd0, 1, 1);
    ld_ir(16'h0000);
    expect_k(16'h8000, 4'b0101);
    idle(1);

    cur_tag = "sub_borrow";
    setreg(1, 16'h0000);
    setreg(2, 16'h0001);
    ld_ir(16'hA209);
    alu(2'd1, 1, 1);
    ld_ir(16'h0000);
    expect_k(16'hFFFF, 4'b0110);
    idle(1);

    cur_tag = "and_zero";
    ld_ir(16'hA334);
    alu(2'd2, 1, 1);
    ld_ir(16'h0003);
    expect_k(16'h0000, 4'b1000);
    idle(1);

    cur_tag = "flag_hold";
    ld_ir(16'hA134);
    alu(2'd0, 1, 1);
    alu(2'd2, 0, 0);
    ld_ir(16'h0000);
    expect_k(16'hFFFF, 4'b0100);
    idle(1);

    cur_tag = "wr_rd";
    ld_ir(16'h0022);
    expect_k(16'h0001, 4'b0100);
    wr(16'h1234);
    expect_k(16'h1234, 4'b0100);
    idle(1);

    cur_tag = "pc";
    ld_ir(16'h001F);
    step(1, 1, 1, 0, 1, 0, 2'd0, 0, 0, 16'h0);
    expect_ra(5'd31);
    step(1, 0, 1, 0, 1, 0, 2'd0, 0, 0, 16'h0);
    expect_ra(5'd0);
    ld_ir(16'h0815);
    step(1, 1, 1, 0, 1, 0, 2'd0, 0, 0, 16'h0);
    expect_ra(5'd21);
    step(1, 1, 0, 0, 1, 0, 2'd0, 0, 0, 16'h0);
    expect_ra(5'd21);
    idle(1);
    ld_ir(16'h0003);
    step(1, 1, 1, 1, 1, 0, 2'd0, 0, 0, 16'h0009);
    expect_ra(5'd3);
    idle(1);
    expect_ra(5'd9);
    idle(0);

    cur_tag = "random";
    for (int i = 0; i < 400; i++) begin
      din = 16'($urandom());
      if ($urandom_range(0, 1) == 1) din[15:8] = 8'(opc_tab[$urandom_range(0, 15)]);
      step($urandom_range(0, 39) != 0, 1'($urandom()), 1'($urandom()), 1'($urandom()),
           1'($urandom()), 1'($urandom()), 2'($urandom()), 1'($urandom()), 1'($urandom()), din);
    end

    cur_tag = "reset";
    setreg(3, 16'hBEEF);
    ld_ir(16'hA1C3);
    step(1, 0, 1, 0, 1, 0, 2'd0, 0, 0, 16'h0);
    step(0, 1, 1, 1, 1, 1, 2'd1, 1, 1, 16'hA5A5);
    expect_k(16'h0000, 4'b0000);
    expect_ra(5'd0);
    idle(1);

    bstep("sweep_ld", 0, 0, 1, 1, 0, 0, 32'h0000_01C0, 32'h0, 8'h00);
    bstep("sweep_wr", 0, 0, 0, 1, 1, 1, 32'hDEAD_BEEF, 32'h0, 8'h00);
    bstep("sweep_ld2", 0, 0, 1, 1, 0, 0, 32'h0000_00FF, 32'h0, 8'h00);
    bstep("sweep_br", 1, 1, 0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF, 8'h00);
    bstep("sweep_wrap", 1, 0, 0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF, 8'hFF);
    bstep("sweep_pc0", 0, 0, 0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF, 8'h00);
    bstep("sweep_iraddr", 0, 0, 0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF, 8'hFF);

    @(negedge clk);
    #1;
    chk("queue_drain_a", 64'(qa.size()), 64'd0);
    chk("queue_drain_b", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ks_data_path_param.md
KS_DATA_PATH_PARAM -- requirements
Module: ks_data_path_param

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 16: datapath, register, IR and memory word width.
- NUM_REGS, 4: register-file depth; power of 2, at least 2.
- ADDR_W, 5: PC and RAM address width.
REQ-002 Derived constant RW = $clog2(NUM_REGS); elaboration SHALL fail if 8+3*RW > DATA_W or 8+ADDR_W > DATA_W.
REQ-003 The block SHALL use one clock, clk; reset rst_n is synchronous and active-low.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- branch  in  1  PC loads the IR address field instead of incrementing.
- pc_enable  in  1  PC update strobe.
- ir_enable  in  1  IR loads data_in.
- addr_sel  in  1  1 = PC drives ram_addr, 0 = IR address field.
- c_sel  in  1  1 = data_in drives bus_c, 0 = ALU result.
- operation  in  2  ALU op.
- write_reg_enable  in  1  register-file write strobe.
- flags_reg_enable  in  1  flags register update strobe.
- data_in  in  DATA_W  RAM read data.
- decoded_instruction  out  decoded_instruction_type  decode of the IR.
- zero_op  out  1  registered flag.
- neg_op  out  1  registered flag.
- unsigned_overflow  out  1  registered flag.
- signed_overflow  out  1  registered flag.
- ram_addr  out  ADDR_W  RAM address.
- data_out  out  DATA_W  RAM write data.

Function
REQ-005 IR fields SHALL be:
- opcode = IR[DATA_W-1 -: 8].
- dst = IR[3*RW-1 -: RW].
- src_b = IR[2*RW-1 -: RW].
- src_a = IR[RW-1:0].
- addr = IR[ADDR_W-1:0].
REQ-006 bus_a = reg[src_a] and bus_b = reg[src_b] SHALL be combinational reads; data_out SHALL equal bus_a with zero cycles of latency.
REQ-007 ALU ops SHALL be 00 ADD, 01 SUB (a-b), 10 AND, 11 OR, all modulo 2^DATA_W.
REQ-008 ALU flags SHALL be:
- zero: result==0.
- neg: result MSB.
- unsigned_overflow: ADD carry-out, or SUB borrow (a<b unsigned).
- signed_overflow: two's-complement overflow.
- For AND/OR both overflow flags SHALL be 0.
REQ-009 On a clk edge with flags_reg_enable=1, the four flag outputs SHALL load the ALU flags; otherwise they SHALL hold.
REQ-010 bus_c SHALL be data_in when c_sel=1, else the ALU result; it SHALL be combinational.
REQ-011 On a clk edge with write_reg_enable=1, reg[dst] SHALL load bus_c; every register is writable, including index 0.
REQ-012 A read of reg[dst] in the write cycle SHALL return the old value; the new value is visible from the next cycle.
REQ-013 On a clk edge with pc_enable=1, PC SHALL load IR addr if branch=1, else PC+1 wrapping 2^ADDR_W-1 -> 0; branch SHALL be ignored when pc_enable=0.
REQ-014 On a clk edge with ir_enable=1, IR SHALL load data_in.
REQ-015 Simultaneous ir_enable and pc_enable with branch=1 SHALL branch to the pre-edge IR addr.
REQ-016 ram_addr SHALL be PC when addr_sel=1, else IR addr; it SHALL be combinational from registers.
REQ-017 decoded_instruction SHALL be a combinational decode of IR opcode via the package table; unlisted opcodes SHALL decode to I_NOP.
REQ-018 All enables SHALL be independent; any combination in one cycle SHALL be legal.

Reset
REQ-019 On a clk edge with rst_n=0, PC, IR, all registers and all flags SHALL become 0, overriding every enable, including mid-instruction.
REQ-020 After reset, decoded_instruction SHALL be I_NOP, ram_addr 0, data_out 0.

Structure
REQ-021 k_and_s_pkg SHALL hold:
- decoded_instruction_type.
- the 8-bit opcode constants and decode function.
- the operation encoding enum.
REQ-022 The ALU SHALL be a separate combinational sub-module, ks_alu, parameterised by DATA_W.
REQ-023 PC, IR, register file and flags SHALL be the only state.

Verification
REQ-024 With DATA_W=16, NUM_REGS=4, ADDR_W=5, the bench SHALL cover these directed scenarios:
- Reset: rst_n=0 for one edge with all enables at 1 -> PC=0, IR=0, flags=0, decoded=I_NOP, ram_addr=0 with addr_sel=1.
- ADD overflow: R1=0x7FFF, R2=0x0001, ADD into R0 with flags enabled -> R0=0x8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- SUB borrow: R1=0x0000, R2=0x0001, SUB -> 0xFFFF, unsigned_overflow=1, neg=1, signed_overflow=0; then AND 0xFFFF&0x0000 -> zero=1, both overflows 0.
- PC wrap and branch: PC=31, pc_enable=1, branch=0 -> PC=0; then IR=0x0815, branch=1 -> PC=21.
- Flag hold and write/read: flags_reg_enable=0 while the ALU result is 0 -> flags unchanged; writing R2=0x1234 with src_a=2 -> data_out is old R2 that cycle and 0x1234 next.
- Parameter sweep: NUM_REGS=8, DATA_W=32, ADDR_W=8 -> register R7 reachable, PC wraps at 255.
